// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for seq_multiplier.
// The master side issues operands and start; the slave side returns the product and status.
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;
  logic                 zflag;

  modport master (
    output start, signed_mode, multiplier, multiplicand,
    input  product, busy, done, zflag
  );

  modport slave (
    input  start, signed_mode, multiplier, multiplicand,
    output product, busy, done, zflag
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add sequential multiplier: sign-magnitude operands, early termination
// once the remaining multiplier bits are zero.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the start edge
//   CALC  | one conditional add and shift per cycle
//   FIN   | apply the result sign, write product, pulse done
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  seq_multiplier_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mplier_q;
  logic [PW-1:0]     mcand_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     product_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic              done_q;
  logic              zflag_q;

  logic [WIDTH-1:0]  mplier_mag;
  logic [WIDTH-1:0]  mcand_mag;
  logic [WIDTH-1:0]  mplier_shift;
  logic [CW-1:0]     cnt_inc;
  logic              calc_last;

  // Negation of the most negative operand wraps to 2^(WIDTH-1), which is its magnitude.
  always_comb begin
    mplier_mag = bus.multiplier;
    mcand_mag  = bus.multiplicand;
    if (bus.signed_mode && bus.multiplier[WIDTH-1])
      mplier_mag = -bus.multiplier;
    if (bus.signed_mode && bus.multiplicand[WIDTH-1])
      mcand_mag = -bus.multiplicand;
  end

  assign mplier_shift = mplier_q >> 1;
  assign cnt_inc      = cnt_q + CW'(1);
  assign calc_last    = (mplier_shift == '0) || (cnt_inc == CW'(WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (calc_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mplier_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
      zflag_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mplier_q <= mplier_mag;
            mcand_q  <= {{WIDTH{1'b0}}, mcand_mag};
            neg_q    <= bus.signed_mode &
                        (bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          if (mplier_q[0])
            acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_shift;
          cnt_q    <= cnt_inc;
        end
        FIN: begin
          product_q <= neg_q ? -acc_q : acc_q;
          // Negating zero is zero, so the accumulator alone decides the flag.
          zflag_q   <= (acc_q == '0);
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.zflag   = zflag_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=8): stimulus pushes expectations,
// a monitor pops and compares on every done pulse.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(8)) mul_if ();
  seq_multiplier #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(mul_if));

  typedef struct {
    string       name;
    logic [15:0] prod;
    logic        z;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mul_if.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_product"}, mul_if.product, e.prod);
          check({e.name, "_zflag"}, mul_if.zflag, e.z);
          check({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
        end
      end
    end
  end

  task automatic drive_push(string name, logic sm, logic [7:0] a, logic [7:0] b,
                            logic [15:0] p, int lat);
    exp_t e;
    mul_if.signed_mode  = sm;
    mul_if.multiplier   = a;
    mul_if.multiplicand = b;
    mul_if.start        = 1'b1;
    e.name      = name;
    e.prod      = p;
    e.z         = (p == 16'h0000);
    e.start_cyc = cyc + 1;
    e.lat       = lat;
    sb.push_back(e);
  endtask

  task automatic issue(string name, logic sm, logic [7:0] a, logic [7:0] b,
                       logic [15:0] p, int lat);
    @(negedge clk);
    drive_push(name, sm, a, b, p, lat);
    @(posedge clk);
    #1;
    mul_if.start = 1'b0;
    check({name, "_busy"}, mul_if.busy, 1'b1);
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mul_if.busy && sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout actual=busy required=idle", name);
  endtask

  // Called at a negedge with the FSM idle or showing done; leaves start high.
  task automatic b2b_step(string name, logic sm, logic [7:0] a, logic [7:0] b,
                          logic [15:0] p, int lat);
    bit seen;
    seen = 1'b0;
    drive_push(name, sm, a, b, p, lat);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (mul_if.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  initial begin
    int done_cnt;
    reset               = 1'b1;
    mul_if.start        = 1'b0;
    mul_if.signed_mode  = 1'b0;
    mul_if.multiplier   = '0;
    mul_if.multiplicand = '0;
    #2;
    check("rst_product", mul_if.product, 16'h0000);
    check("rst_busy", mul_if.busy, 1'b0);
    check("rst_done", mul_if.done, 1'b0);
    check("rst_zflag", mul_if.zflag, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    issue("u13x11", 1'b0, 8'd13, 8'd11, 16'h008F, 5);          wait_idle("u13x11");
    issue("s_m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1, 3);          wait_idle("s_m3x5");
    issue("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000, 9);         wait_idle("s_80x80");
    issue("u_zero", 1'b0, 8'h00, 8'h5A, 16'h0000, 2);          wait_idle("u_zero");
    issue("s_zero", 1'b1, 8'h00, 8'h80, 16'h0000, 2);          wait_idle("s_zero");
    issue("s_1xC8", 1'b1, 8'h01, 8'hC8, 16'hFFC8, 2);          wait_idle("s_1xC8");
    issue("s_7Fx81", 1'b1, 8'h7F, 8'h81, 16'hC0FF, 8);         wait_idle("s_7Fx81");
    issue("s_80x7F", 1'b1, 8'h80, 8'h7F, 16'hC080, 9);         wait_idle("s_80x7F");
    issue("s_FFxFF", 1'b1, 8'hFF, 8'hFF, 16'h0001, 2);         wait_idle("s_FFxFF");
    issue("u_80x02", 1'b0, 8'h80, 8'h02, 16'h0100, 9);         wait_idle("u_80x02");
    issue("u_02xFF", 1'b0, 8'h02, 8'hFF, 16'h01FE, 3);         wait_idle("u_02xFF");
    issue("u_FFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 9);         wait_idle("u_FFxFF");

    // Second start and operand changes while the first operation is in CALC.
    issue("ignore", 1'b0, 8'd13, 8'd11, 16'h008F, 5);
    @(negedge clk);
    mul_if.start        = 1'b1;
    mul_if.signed_mode  = 1'b1;
    mul_if.multiplier   = 8'h00;
    mul_if.multiplicand = 8'h22;
    @(negedge clk);
    mul_if.start        = 1'b0;
    mul_if.multiplier   = 8'h77;
    mul_if.multiplicand = 8'h99;
    wait_idle("ignore");

    // Asynchronous abort mid-CALC; product from the previous run is non-zero.
    issue("abort", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 9);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_product", mul_if.product, 16'h0000);
    check("abort_busy", mul_if.busy, 1'b0);
    check("abort_done", mul_if.done, 1'b0);
    check("abort_zflag", mul_if.zflag, 1'b1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (mul_if.done === 1'b1) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    issue("post_rst", 1'b0, 8'd6, 8'd7, 16'h002A, 4);          wait_idle("post_rst");

    // Start held high: each capture lands on the edge after done.
    @(negedge clk);
    b2b_step("b2b_0", 1'b0, 8'd3, 8'd7, 16'h0015, 3);
    b2b_step("b2b_1", 1'b1, 8'hFE, 8'h03, 16'hFFFA, 3);
    b2b_step("b2b_2", 1'b0, 8'd5, 8'd5, 16'h0019, 4);
    b2b_step("b2b_3", 1'b0, 8'd0, 8'd9, 16'h0000, 2);
    mul_if.start = 1'b0;
    wait_idle("b2b");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a new multiplication; sampled only in IDLE.
REQ-005 Port: signed_mode  input  1  operands are two's complement when 1 and unsigned when 0; captured with start.
REQ-006 Port: multiplier  input  WIDTH  first operand; captured with start.
REQ-007 Port: multiplicand  input  WIDTH  second operand; captured with start.
REQ-008 Port: product  output  2*WIDTH  registered result; held until the next result is written.
REQ-009 Port: busy  output  1  high in every state other than IDLE.
REQ-010 Port: done  output  1  one-cycle pulse when product becomes valid.
REQ-011 Port: zflag  output  1  high while product equals 0.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, CALC and FIN.
REQ-013 In IDLE, start=1 at an edge SHALL capture the operands and signed_mode and move the FSM to CALC.
REQ-014 Operand capture SHALL store magnitudes: in signed_mode each negative operand is negated to WIDTH-bit unsigned, so -2^(WIDTH-1) becomes 2^(WIDTH-1).
REQ-015 Operand capture SHALL register the result sign as the XOR of the operand MSBs when signed_mode=1, and 0 otherwise.
REQ-016 Operand capture SHALL clear the 2*WIDTH-bit accumulator and the iteration counter.
REQ-017 Each CALC edge SHALL add the shifted multiplicand to the accumulator if the multiplier LSB is 1, then shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
REQ-018 The FSM SHALL leave CALC for FIN on the edge where the post-shift multiplier is zero or the counter reaches WIDTH (early termination).
REQ-019 CALC SHALL take k+1 cycles, where k is the index of the highest set bit of the multiplier magnitude (k=0 when the magnitude is 0 or 1).
REQ-020 The FIN edge SHALL write product as the two's-complement negation of the accumulator if the sign bit is 1, or the accumulator otherwise, and SHALL set done=1 and return the FSM to IDLE.
REQ-021 done SHALL be high for exactly one cycle, the cycle following the FIN edge; start may be accepted in that same cycle.
REQ-022 Total latency from the start edge to done high SHALL be k+2 edges.
REQ-023 start while busy=1 SHALL be ignored, with no effect on operands or state.
REQ-024 Input changes after capture SHALL NOT affect the result.
REQ-025 Accumulator arithmetic SHALL be 2*WIDTH bits wide, and no overflow can occur.
REQ-026 Signed results SHALL lie in [-2^(2W-2)+2^(W-1), 2^(2W-2)].
REQ-027 Unsigned results SHALL lie in [0, (2^W-1)^2].
REQ-028 product and zflag SHALL change only on the FIN edge or on reset.

Reset
REQ-029 Asserting reset SHALL immediately, without waiting for clk, force state=IDLE, product=0, busy=0, done=0, zflag=1, and clear all internal registers.
REQ-030 Reset asserted during CALC or FIN SHALL abort the operation, with no done pulse and no product update.
REQ-031 After reset deasserts, the first rising clk edge with start=1 SHALL begin a new operation normally.

Verification (WIDTH=8)
REQ-032 Unsigned 13 x 11, signed_mode=0 -> product=0x008F, done at start edge+5, zflag=0.
REQ-033 Signed -3 x 5, i.e. 0xFD x 0x05 with signed_mode=1 -> product=0xFFF1.
REQ-034 Signed 0x80 x 0x80 -> product=0x4000.
REQ-035 Unsigned 0xFF x 0xFF -> product=0xFE01, done at start edge+9.
REQ-036 Multiplier 0 with any multiplicand -> product=0x0000, zflag=1, done at start edge+2.
REQ-037 start pulsed again during CALC with different operands -> first result unchanged.
REQ-038 Reset mid-CALC -> product=0, busy=0 with no clk edge, and no done pulse.
REQ-039 Back-to-back: start held high -> a new capture on the edge after each done, and every result is correct.
